data_mem_unit: RTL

- Data-side memory stage directly downstream of the single-cycle CPU core. It consumes the core's address (ALUResult), MemWrite, funct3 and WriteData, and returns ReadData in the same cycle.
- Performs RISC-V byte, half and word store merging, and load sign or zero extension.
- Detects misaligned accesses and hosts a memory-mapped 64-bit machine timer with a compare interrupt.

---
 rtl/data_mem_unit_pkg.sv | 33 +++
 rtl/data_mem_unit_mem_timer.sv | 56 +++++
 rtl/data_mem_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/data_mem_unit_pkg.sv
// Shared encodings for the data memory stage: funct3 access codes, timer register offsets, timer reset values.
// Also holds the access-size decode helper used by the store and load paths.
package data_mem_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MTIME_LO    = 4'h0;
    localparam logic [3:0] MTIME_HI    = 4'h4;
    localparam logic [3:0] MTIMECMP_LO = 4'h8;
    localparam logic [3:0] MTIMECMP_HI = 4'hC;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Reserved encodings (011, 110, 111) fall through to word size.
    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_unit_mem_timer.sv
// 64-bit mtime/mtimecmp pair with a word write port and a registered compare interrupt (used under DATA_MEM_TIMER_EN).
// Writes land on the next edge, reads are combinational, irq lags the registers by one cycle; never stalls.
module data_mem_unit_mem_timer
    import data_mem_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [3:0]  off,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [63:0] mtime, mtime_nxt;
    logic [63:0] mtimecmp, mtimecmp_nxt;

    // A written half loses this cycle's increment; the untouched half increments without the low-word carry.
    always_comb begin
        mtime_nxt    = mtime + 64'd1;
        mtimecmp_nxt = mtimecmp;
        if (wr_en) begin
            case (off)
                MTIME_LO:    mtime_nxt = {mtime[63:32], wdata};
                MTIME_HI:    mtime_nxt = {wdata, mtime[31:0] + 32'd1};
                MTIMECMP_LO: mtimecmp_nxt = {mtimecmp[63:32], wdata};
                MTIMECMP_HI: mtimecmp_nxt = {wdata, mtimecmp[31:0]};
                default:     mtime_nxt = mtime + 64'd1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime    <= '0;
            mtimecmp <= MTIMECMP_RST;
            irq      <= 1'b0;
        end else begin
            mtime    <= mtime_nxt;
            mtimecmp <= mtimecmp_nxt;
            irq      <= (mtime >= mtimecmp);
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            MTIME_LO:    rdata = mtime[31:0];
            MTIME_HI:    rdata = mtime[63:32];
            MTIMECMP_LO: rdata = mtimecmp[31:0];
            MTIMECMP_HI: rdata = mtimecmp[63:32];
            default:     rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// Data-side memory stage: byte/half/word RAM with store merging, load extension, sticky misalignment capture, optional MMIO timer (DATA_MEM_TIMER_EN).
// Loads combinational, stores commit on the next edge; no backpressure, every access completes in its cycle.
module data_mem_unit
    import data_mem_unit_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] Addr,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  funct3,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        misaligned,
    output logic [31:0] misaligned_addr,
    output logic        timer_irq
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    size_e          sz;
    logic           access;
    logic           mis;
    logic           ram_hit;
    logic [AW-1:0]  idx;
    logic [3:0]     be;
    logic [31:0]    wlane;
    logic           ram_we;
    logic [31:0]    mmio_word;
    logic [31:0]    rword;
    logic [31:0]    shifted;
    logic [31:0]    ext;

    logic [31:0] ram [DEPTH_WORDS];

    assign sz      = f3_size(funct3);
    assign access  = MemRead | MemWrite;
    assign mis     = access && (((sz == SZ_H) && Addr[0]) || ((sz == SZ_W) && (Addr[1:0] != 2'b00)));
    assign ram_hit = (Addr < RAM_BYTES);
    assign idx     = Addr[AW+1:2];
    assign ram_we  = MemWrite && ram_hit && !mis;

    always_comb begin
        be    = 4'b1111;
        wlane = WriteData;
        case (sz)
            SZ_B: begin
                be    = 4'b0001 << Addr[1:0];
                wlane = {4{WriteData[7:0]}};
            end
            SZ_H: begin
                be    = Addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{WriteData[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = WriteData;
            end
        endcase
    end

    // Sampling Reset here drops a store that coincides with reset assertion.
    always_ff @(posedge clk) begin
        if (Reset && ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

`ifdef DATA_MEM_TIMER_EN
    logic        mmio_word_ok;
    logic [31:0] tmr_rdata;

    assign mmio_word_ok = (Addr[31:4] == MMIO_BASE[31:4]) && (sz == SZ_W) && !mis;
    assign mmio_word    = mmio_word_ok ? tmr_rdata : '0;

    data_mem_unit_mem_timer u_timer (
        .clk   (clk),
        .rst_n (Reset),
        .wr_en (MemWrite && mmio_word_ok),
        .off   (Addr[3:0]),
        .wdata (WriteData),
        .rdata (tmr_rdata),
        .irq   (timer_irq)
    );
`else
    assign mmio_word = '0;
    assign timer_irq = 1'b0;
`endif

    assign rword   = ram_hit ? ram[idx] : mmio_word;
    assign shifted = rword >> {Addr[1:0], 3'b000};

    always_comb begin
        ext = rword;
        case (funct3)
            F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ext = {24'd0, shifted[7:0]};
            F3_HU:   ext = {16'd0, shifted[15:0]};
            F3_W:    ext = rword;
            default: ext = rword;
        endcase
    end

    assign ReadData = (MemRead && !mis) ? ext : '0;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            misaligned      <= 1'b0;
            misaligned_addr <= '0;
        end else if (mis && !misaligned) begin
            misaligned      <= 1'b1;
            misaligned_addr <= Addr;
        end
    end

endmodule
